// File: rtl/template_match_seq.sv
// Sequences one GRIDxGRID template scan: per cell issue coordinates, wait LOOKUP_LAT, take one pixel
// by valid/ready, accumulate |pixel - template|; reports SAD and match flag at scan end.
module template_match_seq #(
    parameter int GRID       = 16,
    parameter int HALVING    = 4,
    parameter int LOOKUP_LAT = 2,
    parameter int SAD_W      = 18
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic             iABORT,
    input  logic [SAD_W-1:0] iTHRESH,
    output logic [12:0]      oTX,
    output logic [12:0]      oTY,
    input  logic [9:0]       iTVAL,
    input  logic [9:0]       iPIX,
    input  logic             iPIX_VAL,
    output logic             oPIX_RDY,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [SAD_W-1:0] oSAD,
    output logic             oMATCH
);
    localparam int CELLS  = GRID * GRID;
    localparam int CELL_W = $clog2(CELLS);
    localparam int GW     = $clog2(GRID);
    localparam int LAT_W  = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FETCH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CELL_W-1:0]  cell_q, cell_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [SAD_W-1:0]   acc_q, acc_d;
    logic [SAD_W-1:0]   thresh_q, thresh_d;
    logic [SAD_W-1:0]   sad_q, sad_d;
    logic               match_q, match_d;
    logic [9:0]         tval_q, tval_d;
    logic [12:0]        tx_q, tx_d, ty_q, ty_d;

    logic               xfer, last_cell, lat_last;
    logic signed [10:0] diff, neg_diff;
    logic [9:0]         abs_diff;
    logic [SAD_W-1:0]   acc_sum;
    logic [CELL_W-1:0]  coord_cell;
    logic [GW-1:0]      cx;
    logic [CELL_W-GW-1:0] cy;

    assign xfer      = (state_q == S_FETCH) && iPIX_VAL;
    assign last_cell = (cell_q == CELL_W'(CELLS - 1));
    assign lat_last  = (lat_q == LAT_W'(LOOKUP_LAT - 1));
    assign diff      = $signed({1'b0, iPIX}) - $signed({1'b0, tval_q});
    assign neg_diff  = -diff;
    assign abs_diff  = diff[10] ? neg_diff[9:0] : diff[9:0];
    assign acc_sum   = acc_q + {{(SAD_W-10){1'b0}}, abs_diff};

    // Coordinates for the cell about to be issued: cell 0 on start, next cell otherwise.
    assign coord_cell = (state_q == S_IDLE) ? '0 : cell_q + CELL_W'(1);
    assign cx         = coord_cell[GW-1:0];
    assign cy         = coord_cell[CELL_W-1:GW];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            cell_q   <= '0;
            lat_q    <= '0;
            acc_q    <= '0;
            thresh_q <= '0;
            sad_q    <= '0;
            match_q  <= 1'b0;
            tval_q   <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
        end else begin
            state_q  <= state_d;
            cell_q   <= cell_d;
            lat_q    <= lat_d;
            acc_q    <= acc_d;
            thresh_q <= thresh_d;
            sad_q    <= sad_d;
            match_q  <= match_d;
            tval_q   <= tval_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (iSTART) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (lat_last) state_d = S_FETCH;
            S_FETCH: if (xfer) state_d = last_cell ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (iABORT) state_d = S_IDLE;
    end

    always_comb begin
        cell_d   = cell_q;
        lat_d    = '0;
        acc_d    = acc_q;
        thresh_d = thresh_q;
        sad_d    = sad_q;
        match_d  = match_q;
        tval_d   = tval_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    acc_d    = '0;
                    cell_d   = '0;
                    thresh_d = iTHRESH;
                    tx_d     = 13'(cx) << HALVING;
                    ty_d     = 13'(cy) << HALVING;
                end
            end
            S_WAIT: begin
                lat_d = lat_q + LAT_W'(1);
                if (lat_last) tval_d = iTVAL;
            end
            S_FETCH: begin
                if (xfer) begin
                    acc_d = acc_sum;
                    if (last_cell) begin
                        sad_d   = acc_sum;
                        match_d = (acc_sum < thresh_q);
                    end else begin
                        cell_d = cell_q + CELL_W'(1);
                        tx_d   = 13'(cx) << HALVING;
                        ty_d   = 13'(cy) << HALVING;
                    end
                end
            end
            default: ;
        endcase
        // Abort discards everything in flight, including a same-cycle pixel transfer.
        if (iABORT) begin
            acc_d    = '0;
            cell_d   = cell_q;
            thresh_d = thresh_q;
            sad_d    = sad_q;
            match_d  = match_q;
            tx_d     = tx_q;
            ty_d     = ty_q;
        end
    end

    always_comb begin
        oPIX_RDY = (state_q == S_FETCH);
        oBUSY    = (state_q != S_IDLE);
        oDONE    = (state_q == S_DONE);
        oSAD     = sad_q;
        oMATCH   = match_q;
        oTX      = tx_q;
        oTY      = ty_q;
    end
endmodule

// File: tb/tb_template_match_seq.sv
// Bench for template_match_seq: table of full scans against a per-cell SAD model, plus abort/reset sequences.
module tb_template_match_seq;
    localparam int SAD_W = 18;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, abort_i, pix_val, pix_rdy, busy, done, match;
    logic [SAD_W-1:0] thresh, sad;
    logic [12:0]      tx, ty;
    logic [9:0]       tval, pix;
    logic [9:0]       tv1, tv2;

    always #5 clk = ~clk;

    template_match_seq dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iABORT(abort_i), .iTHRESH(thresh),
        .oTX(tx), .oTY(ty), .iTVAL(tval), .iPIX(pix), .iPIX_VAL(pix_val),
        .oPIX_RDY(pix_rdy), .oBUSY(busy), .oDONE(done), .oSAD(sad), .oMATCH(match)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int tmode = 0;
    int pix_arr[256];

    int xfers, done_cnt, done_n, rdy_bad, coord_bad, sad_at_done, match_at_done, loop_n;

    function automatic int tmpl(input int x, input int y);
        if (tmode == 0) return 1023;
        return (x * 37 + y * 11 + 5) % 1024;
    endfunction

    // Two-stage lookup: value appears two cycles after the coordinates.
    always @(posedge clk) begin
        tv1 <= 10'(tmpl(int'(tx), int'(ty)));
        tv2 <= tv1;
    end
    assign tval = tv2;

    function automatic int ref_sad();
        int s = 0;
        for (int c = 0; c < 256; c++) begin
            int d = pix_arr[c] - tmpl((c % 16) * 16, (c / 16) * 16);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tx"}, tx, 0);
        check({tag, "_ty"}, ty, 0);
        check({tag, "_sad"}, sad, 0);
        check({tag, "_match"}, match, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rdy"}, pix_rdy, 0);
    endtask

    // kind: 0 normal, 1 iSTART pulse at cell 100, 2 iABORT at cell 100, 3 iRST at cell 50
    task automatic run_scan(input int thr, input bit gaps, input int kind);
        int  stall;
        bit  xfer, prev_xfer;
        xfers = 0; done_cnt = 0; done_n = -1; rdy_bad = 0; coord_bad = 0;
        stall = 0; prev_xfer = 0;
        @(negedge clk);
        thresh = SAD_W'(thr);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (loop_n = 0; loop_n < 3000; loop_n++) begin
            if (done) begin
                done_cnt++;
                if (done_n < 0) begin
                    done_n        = loop_n;
                    sad_at_done   = int'(sad);
                    match_at_done = int'(match);
                end
            end
            if (pix_rdy && (!busy || done || prev_xfer)) rdy_bad++;
            if (done_n >= 0 && loop_n >= done_n + 3) break;
            start   = 1'b0;
            abort_i = 1'b0;
            if (stall > 0) begin
                pix_val = 1'b0;
                stall--;
            end else if (gaps && pix_rdy && $urandom_range(0, 3) == 0) begin
                pix_val = 1'b0;
                stall   = 2;
            end else begin
                pix_val = gaps ? (pix_rdy ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
            end
            pix = (pix_rdy && xfers < 256) ? 10'(pix_arr[xfers]) : 10'($urandom_range(0, 1023));
            if (pix_rdy && kind == 1 && xfers == 100) start = 1'b1;
            if (pix_rdy && kind == 2 && xfers == 100) begin
                abort_i = 1'b1;
                pix_val = 1'b1;
            end
            if (pix_rdy && kind == 3 && xfers == 50) begin
                rst = 1'b1;
                #1;
                check_zero_outputs("midscan_reset");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            xfer = pix_val && pix_rdy && !abort_i;
            if (xfer) begin
                if (int'(tx) != (xfers % 16) * 16 || int'(ty) != (xfers / 16) * 16) coord_bad++;
                if (xfers == 17)  begin check("cell17_tx", tx, 16);   check("cell17_ty", ty, 16);   end
                if (xfers == 255) begin check("cell255_tx", tx, 240); check("cell255_ty", ty, 240); end
                xfers++;
            end
            prev_xfer = xfer;
            if (abort_i) begin
                @(negedge clk);
                abort_i = 1'b0;
                pix_val = 1'b0;
                check("abort_to_idle", busy, 0);
                repeat (40) begin
                    if (done) done_cnt++;
                    @(negedge clk);
                end
                return;
            end
            @(negedge clk);
        end
        pix_val = 1'b0;
    endtask

    task automatic fill_pix(input int pmode, input int pval);
        if (pmode == 2) return;
        for (int c = 0; c < 256; c++) pix_arr[c] = (pmode == 0) ? pval : int'($urandom_range(0, 1023));
    endtask

    task automatic check_scan(input string tag, input bit gaps, input int exp_sad, input int exp_match);
        check({tag, "_in_budget"}, (loop_n < 3000), 1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        if (!gaps) check({tag, "_latency"}, done_n, 1024);
        check({tag, "_transfers"}, xfers, 256);
        check({tag, "_sad"}, sad_at_done, exp_sad);
        check({tag, "_match"}, match_at_done, exp_match);
        check({tag, "_sad_held"}, sad, exp_sad);
        check({tag, "_rdy_only_fetch"}, rdy_bad, 0);
        check({tag, "_coords"}, coord_bad, 0);
    endtask

    typedef struct {
        int tmode;
        int pmode;     // 0 constant pval, 1 fresh random, 2 reuse previous pixels
        int pval;
        int thr;
        bit gaps;
        int exp_sad;   // -1: take from reference model
        int exp_match;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int   exp_s, exp_m, thr_r;
        tbl[0] = '{0, 0, 1023, 1,      1'b0, 0,      1};
        tbl[1] = '{0, 0, 0,    1000,   1'b0, 261888, 0};
        tbl[2] = '{1, 1, 0,    90000,  1'b0, -1,     -1};
        tbl[3] = '{1, 2, 0,    90000,  1'b1, -1,     -1};
        tbl[4] = '{1, 1, 0,    262143, 1'b1, -1,     -1};

        rst = 1'b1; start = 1'b0; abort_i = 1'b0; thresh = '0; pix = '0; pix_val = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            tmode = tbl[i].tmode;
            fill_pix(tbl[i].pmode, tbl[i].pval);
            exp_s = (tbl[i].exp_sad < 0) ? ref_sad() : tbl[i].exp_sad;
            exp_m = (tbl[i].exp_match < 0) ? int'(exp_s < tbl[i].thr) : tbl[i].exp_match;
            run_scan(tbl[i].thr, tbl[i].gaps, 0);
            check_scan($sformatf("vec%0d", i), tbl[i].gaps, exp_s, exp_m);
        end

        // iSTART mid-scan is ignored.
        tmode = 0;
        fill_pix(0, 0);
        run_scan(1000, 1'b0, 1);
        check_scan("start_ignored", 1'b0, 261888, 0);

        // Abort at cell 100 keeps previous results and never pulses oDONE.
        tmode = 1;
        fill_pix(1, 0);
        run_scan(1, 1'b0, 2);
        check("abort_no_done", done_cnt, 0);
        check("abort_sad_kept", sad, 261888);
        check("abort_match_kept", match, 0);

        // Restart after abort.
        thr_r = int'($urandom_range(60000, 120000));
        exp_s = ref_sad();
        run_scan(thr_r, 1'b1, 0);
        check_scan("restart", 1'b1, exp_s, int'(exp_s < thr_r));

        // Abort beats start in IDLE.
        @(negedge clk);
        start = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        start = 1'b0; abort_i = 1'b0;
        check("abort_beats_start", busy, 0);

        // Reset mid-scan, then a fresh scan matches the all-zero-pixel result.
        tmode = 0;
        fill_pix(0, 0);
        run_scan(1000, 1'b0, 3);
        run_scan(1000, 1'b0, 0);
        check_scan("after_reset", 1'b0, 261888, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
